// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message sequencer.
// SHA256_IV is the standard initial hash value, kept here so benches can reuse it.
`timescale 1ns/1ps
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        OUT       = 3'd4
    } seq_state_t;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 256;

    localparam logic [DIGEST_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_msg_seq.sv
// Multi-block message sequencer feeding one shared SHA-256 compression core.
// Optional SHA_SEQ_MIDSTATE_EN adds msg_init/msg_init_en to resume from a stored midstate.
`timescale 1ns/1ps
module sha256_msg_seq
    import sha256_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                blk_valid,
    output logic                blk_ready,
    input  logic [BLOCK_W-1:0]  blk_data,
    input  logic                blk_last,
`ifdef SHA_SEQ_MIDSTATE_EN
    input  logic [DIGEST_W-1:0] msg_init,
    input  logic                msg_init_en,
`endif
    output logic                dig_valid,
    input  logic                dig_ready,
    output logic [DIGEST_W-1:0] dig_data,
    output logic                core_start,
    output logic [BLOCK_W-1:0]  core_block,
    output logic [DIGEST_W-1:0] core_hash_init,
    output logic                core_use_init,
    input  logic [DIGEST_W-1:0] core_hash,
    input  logic                core_ready,
    output logic                busy,
    output logic [CNT_W-1:0]    blk_count
);

    seq_state_t          state_q, state_d;
    logic [BLOCK_W-1:0]  block_q;
    logic                last_q;
    logic                first_q;
    logic [DIGEST_W-1:0] chain_q;
    logic [DIGEST_W-1:0] hash_init_q;
    logic                use_init_q;
    logic [DIGEST_W-1:0] dig_data_q;
    logic [CNT_W-1:0]    count_q;
    logic                live_q;
    logic                accept;

    // live_q keeps blk_ready low until the first edge after reset releases
    assign blk_ready      = live_q && (state_q == IDLE);
    assign accept         = blk_valid && blk_ready;
    assign dig_valid      = (state_q == OUT);
    assign core_start     = (state_q == START);
    assign busy           = (state_q != IDLE);
    assign core_block     = block_q;
    assign core_hash_init = hash_init_q;
    assign core_use_init  = use_init_q;
    assign dig_data       = dig_data_q;
    assign blk_count      = count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = START;
            START:     state_d = WAIT_ACK;
            WAIT_ACK:  if (!core_ready) state_d = WAIT_DONE;
            WAIT_DONE: if (core_ready) state_d = last_q ? OUT : IDLE;
            OUT:       if (dig_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            block_q     <= '0;
            last_q      <= 1'b0;
            first_q     <= 1'b1;
            chain_q     <= '0;
            hash_init_q <= '0;
            use_init_q  <= 1'b0;
            dig_data_q  <= '0;
            count_q     <= '0;
            live_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            // Core-facing block and chaining value are captured once and held until the next block
            if (accept) begin
                block_q <= blk_data;
                last_q  <= blk_last;
`ifdef SHA_SEQ_MIDSTATE_EN
                if (first_q && msg_init_en) begin
                    use_init_q  <= 1'b1;
                    hash_init_q <= msg_init;
                end else begin
                    use_init_q  <= !first_q;
                    hash_init_q <= chain_q;
                end
`else
                use_init_q  <= !first_q;
                hash_init_q <= chain_q;
`endif
            end
            if (state_q == WAIT_DONE && core_ready) begin
                chain_q <= core_hash;
                if (count_q != '1) count_q <= count_q + CNT_W'(1);
                if (last_q) dig_data_q <= core_hash;
                else        first_q    <= 1'b0;
            end
            if (state_q == OUT && dig_ready) begin
                first_q <= 1'b1;
                count_q <= '0;
            end
        end
    end

endmodule
